psr_cond_unit: RTL and testbench
================================

# psr_cond_unit

Processor status register and branch-condition resolver placed directly downstream of the ALU. It captures the ALU `psr_flags` word into an architectural PSR under per-group write enables. It evaluates the 4-bit Bcond/Jcond condition field against those flags and returns a registered taken/next-PC decision to the fetch stage over a valid/ready handshake.

## Interface
- `PC_W`, default 16: PC and target width.
- `clk`, in, 1: system clock, rising-edge.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `flags_in`, in, 16: ALU flag word; C=bit0, L=bit2, F=bit5, Z=bit6, N=bit7; other bits ignored.
- `we_cf`, in, 1: load C and F from `flags_in` (ADD/ADDI/SUB/SUBI).
- `we_lnz`, in, 1: load L, N and Z from `flags_in` (CMP/CMPI).
- `req_valid`, in, 1: branch/jump resolve request.
- `req_ready`, out, 1: unit can accept a request.
- `req_cond`, in, 4: condition code.
- `req_is_jump`, in, 1: 1 = Jcond (absolute target), 0 = Bcond (PC-relative).
- `req_pc`, in, PC_W: PC of the branch instruction.
- `req_disp`, in, 8: Bcond displacement, two's complement.
- `req_target`, in, PC_W: Jcond target register value.
- `rsp_valid`, out, 1: decision available.
- `rsp_ready`, in, 1: fetch consumes the decision.
- `rsp_taken`, out, 1: condition true.
- `rsp_next_pc`, out, PC_W: resolved next PC.
- `psr_out`, out, 16: `{8'b0,N,Z,F,2'b00,L,1'b0,C}`.
- `psr_save`, `psr_restore`, in, 1 each: shadow control. Present only with the shadow feature; see Configuration.

## Operation
- PSR is five flops: C, L, F, Z, N. Each group updates on the clock edge when its enable is high. Both enables high updates all five.
- Condition table (CR16): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 HI L; 0101 LS !L; 0110 GT N; 0111 LE !N; 1000 FS F; 1001 FC !F; 1010 LO !L&!Z; 1011 HS L|Z; 1100 LT !N&!Z; 1101 GE N|Z; 1110 UC 1; 1111 never 0.
- Flag bypass: a request accepted in the same cycle as `we_*` evaluates against the incoming flags for the enabled groups and the PSR flops for the rest.
- Target for Bcond is `req_pc + sext(req_disp)`. Target for Jcond is `req_target`. `rsp_next_pc` is the target when taken, otherwise `req_pc + 1`. All arithmetic is modulo 2^PC_W; 0xFFFF+1 wraps to 0.
- FSM states:
  - IDLE: `req_ready`=1; on `req_valid`, go to RESP.
  - RESP: `rsp_valid`=1; `req_ready`=`rsp_ready`.
    - `rsp_ready` and `req_valid` together: back-to-back; stay in RESP with new data.
    - `rsp_ready` only: go to IDLE.
    - Neither: hold, with response fields stable.
- Flag writes while a response is held do not alter the held `rsp_taken`.

## Timing
- Resolve latency: 1 cycle. Request accepted at edge k, response valid after edge k.
- Throughput: 1 request per cycle while `rsp_ready`=1.
- `psr_out` reflects a flag write from the edge after `we_*`.
- Reset values: PSR=0, `psr_out`=0, state IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_taken`=0, `rsp_next_pc`=0, shadow=0.
- Reset asserted mid-handshake drops the pending response immediately and asynchronously. Nothing is replayed.

## Configuration
- `PSR_SHADOW_EN` defined: adds the `psr_save`/`psr_restore` ports and a 5-bit shadow register.
  - `psr_save` copies the PSR into the shadow.
  - `psr_restore` copies the shadow into the PSR and overrides `we_*` that cycle.
  - `psr_restore` and `psr_save` together: restore wins and the shadow is unchanged.
  - Bypass sees the restored value.
- `PSR_SHADOW_EN` undefined: neither port nor the shadow register exists.

## Structure
- The shared package holds:
  - flag bit-index constants (C_BIT=0, L_BIT=2, F_BIT=5, Z_BIT=6, N_BIT=7);
  - the 4-bit condition-code localparams (EQ…NEVER);
  - the FSM state encoding.
- The condition evaluator is one combinational sub-module, `cond_eval` (flags, cond → true).

## Test plan
- Flag capture: `flags_in`=0x00E5 with `we_lnz`=1 only → `psr_out`=0x00C4 (L, Z and N loaded; C and F unchanged at 0).
- Condition sweep:
  - PSR Z=1, all 16 codes issued → taken only for EQ, LS, HS, GE, UC, LE, CC, FC.
  - Every response comes one cycle after its request.
- Bcond wrap: `req_pc`=0xFFFE, `req_disp`=0x03, UC → `rsp_next_pc`=0x0001. Same request with NE and Z=1 → `rsp_next_pc`=0xFFFF.
- Bypass: CMP writes Z=1 (`we_lnz`) in the same cycle as an EQ request, with PSR Z=0 beforehand → `rsp_taken`=1.
- Backpressure: `rsp_ready` held 0 for 3 cycles while flags change → `rsp_valid` and data stable, `req_ready`=0. Release → next request accepted the same cycle.
- Reset while RESP is held → `rsp_valid`=0 and `psr_out`=0 immediately. With `PSR_SHADOW_EN`: save 0x0085, clear, restore → `psr_out`=0x0085.

Source files
------------

// File: rtl/psr_cond_pkg.sv
// Shared definitions for the PSR / branch-condition unit: flag bit positions,
// CR16 condition codes, FSM state encoding and the packed PSR layout.
package psr_cond_pkg;

  localparam int C_BIT = 0;
  localparam int L_BIT = 2;
  localparam int F_BIT = 5;
  localparam int Z_BIT = 6;
  localparam int N_BIT = 7;

  localparam logic [3:0] COND_EQ    = 4'b0000;
  localparam logic [3:0] COND_NE    = 4'b0001;
  localparam logic [3:0] COND_CS    = 4'b0010;
  localparam logic [3:0] COND_CC    = 4'b0011;
  localparam logic [3:0] COND_HI    = 4'b0100;
  localparam logic [3:0] COND_LS    = 4'b0101;
  localparam logic [3:0] COND_GT    = 4'b0110;
  localparam logic [3:0] COND_LE    = 4'b0111;
  localparam logic [3:0] COND_FS    = 4'b1000;
  localparam logic [3:0] COND_FC    = 4'b1001;
  localparam logic [3:0] COND_LO    = 4'b1010;
  localparam logic [3:0] COND_HS    = 4'b1011;
  localparam logic [3:0] COND_LT    = 4'b1100;
  localparam logic [3:0] COND_GE    = 4'b1101;
  localparam logic [3:0] COND_UC    = 4'b1110;
  localparam logic [3:0] COND_NEVER = 4'b1111;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_e;

  typedef struct packed {
    logic n;
    logic z;
    logic f;
    logic l;
    logic c;
  } psr_t;

  // Architectural PSR word as seen by software: {8'b0,N,Z,F,2'b00,L,1'b0,C}.
  function automatic logic [15:0] psr_to_word(input psr_t p);
    logic [15:0] w;
    w        = '0;
    w[C_BIT] = p.c;
    w[L_BIT] = p.l;
    w[F_BIT] = p.f;
    w[Z_BIT] = p.z;
    w[N_BIT] = p.n;
    return w;
  endfunction

endpackage

// File: rtl/psr_cond_unit_cond_eval.sv
// Combinational CR16 condition evaluator: decides whether a 4-bit condition
// code holds for a given set of PSR flags.
module cond_eval
  import psr_cond_pkg::*;
(
  input  psr_t       flags_i,
  input  logic [3:0] cond_i,
  output logic       true_o
);

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    true_o = 1'b0;
    case (cond_i)
      COND_EQ:    true_o =  flags_i.z;
      COND_NE:    true_o = !flags_i.z;
      COND_CS:    true_o =  flags_i.c;
      COND_CC:    true_o = !flags_i.c;
      COND_HI:    true_o =  flags_i.l;
      COND_LS:    true_o = !flags_i.l;
      COND_GT:    true_o =  flags_i.n;
      COND_LE:    true_o = !flags_i.n;
      COND_FS:    true_o =  flags_i.f;
      COND_FC:    true_o = !flags_i.f;
      COND_LO:    true_o = !flags_i.l && !flags_i.z;
      COND_HS:    true_o =  flags_i.l ||  flags_i.z;
      COND_LT:    true_o = !flags_i.n && !flags_i.z;
      COND_GE:    true_o =  flags_i.n ||  flags_i.z;
      COND_UC:    true_o = 1'b1;
      COND_NEVER: true_o = 1'b0;
      default:    true_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/psr_cond_unit.sv
// PSR capture plus registered branch/jump resolver with valid/ready handshake.
// Optional PSR_SHADOW_EN macro adds psr_save/psr_restore and a shadow PSR.
module psr_cond_unit
  import psr_cond_pkg::*;
#(
  parameter int PC_W = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [15:0]     flags_in,
  input  logic            we_cf,
  input  logic            we_lnz,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [3:0]      req_cond,
  input  logic            req_is_jump,
  input  logic [PC_W-1:0] req_pc,
  input  logic [7:0]      req_disp,
  input  logic [PC_W-1:0] req_target,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic            rsp_taken,
  output logic [PC_W-1:0] rsp_next_pc,
  output logic [15:0]     psr_out
`ifdef PSR_SHADOW_EN
  ,
  input  logic            psr_save,
  input  logic            psr_restore
`endif
);

  psr_t            psr_q, psr_d;
  state_e          state_q, state_d;
  logic            taken_q, taken_d;
  logic [PC_W-1:0] next_pc_q, next_pc_d;
  logic [PC_W-1:0] target, seq_pc;
  logic            accept;

  logic unused_flags;
  assign unused_flags = ^{flags_in[15:8], flags_in[4:3], flags_in[1]};

`ifdef PSR_SHADOW_EN
  psr_t shadow_q, shadow_d;
`endif

  // psr_d doubles as the bypass source: a request accepted this cycle sees
  // the flags that will be in the PSR after the edge.
  always_comb begin
    psr_d = psr_q;
    if (we_cf) begin
      psr_d.c = flags_in[C_BIT];
      psr_d.f = flags_in[F_BIT];
    end
    if (we_lnz) begin
      psr_d.l = flags_in[L_BIT];
      psr_d.n = flags_in[N_BIT];
      psr_d.z = flags_in[Z_BIT];
    end
`ifdef PSR_SHADOW_EN
    if (psr_restore) psr_d = shadow_q;
`endif
  end

`ifdef PSR_SHADOW_EN
  always_comb begin
    shadow_d = shadow_q;
    if (psr_save && !psr_restore) shadow_d = psr_q;
  end
`endif

  cond_eval u_cond_eval (
    .flags_i (psr_d),
    .cond_i  (req_cond),
    .true_o  (taken_d)
  );

  assign target    = req_is_jump ? req_target
                                 : req_pc + {{(PC_W-8){req_disp[7]}}, req_disp};
  assign seq_pc    = req_pc + PC_W'(1);
  assign next_pc_d = taken_d ? target : seq_pc;

  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        req_ready = rsp_ready;
        if (rsp_ready && !req_valid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept = req_valid && req_ready;

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      psr_q     <= '0;
      taken_q   <= 1'b0;
      next_pc_q <= '0;
    end else begin
      state_q <= state_d;
      psr_q   <= psr_d;
      if (accept) begin
        taken_q   <= taken_d;
        next_pc_q <= next_pc_d;
      end
    end
  end

`ifdef PSR_SHADOW_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) shadow_q <= '0;
    else          shadow_q <= shadow_d;
  end
`endif

  assign rsp_taken   = taken_q;
  assign rsp_next_pc = next_pc_q;
  assign psr_out     = psr_to_word(psr_q);

endmodule

// File: tb/tb_psr_cond_unit.sv
// Self-checking bench for psr_cond_unit: word-level reference model compared
// every cycle, plus literal expectations from hand-worked scenarios.
module tb_psr_cond_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] flags_in;
  logic        we_cf, we_lnz;
  logic        req_valid, req_ready;
  logic [3:0]  req_cond;
  logic        req_is_jump;
  logic [15:0] req_pc, req_target;
  logic [7:0]  req_disp;
  logic        rsp_valid, rsp_ready, rsp_taken;
  logic [15:0] rsp_next_pc, psr_out;
  logic        psr_save, psr_restore;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  psr_cond_unit #(.PC_W(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .flags_in    (flags_in),
    .we_cf       (we_cf),
    .we_lnz      (we_lnz),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_cond    (req_cond),
    .req_is_jump (req_is_jump),
    .req_pc      (req_pc),
    .req_disp    (req_disp),
    .req_target  (req_target),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_taken   (rsp_taken),
    .rsp_next_pc (rsp_next_pc),
    .psr_out     (psr_out)
`ifdef PSR_SHADOW_EN
    ,
    .psr_save    (psr_save),
    .psr_restore (psr_restore)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] cc, input logic jmp, input logic [15:0] pc,
                       input logic [7:0] disp, input logic [15:0] tgt);
    req_valid   = 1'b1;
    req_cond    = cc;
    req_is_jump = jmp;
    req_pc      = pc;
    req_disp    = disp;
    req_target  = tgt;
  endtask

  // Reference condition table, working on the architectural PSR word.
  function automatic logic model_cond(input logic [15:0] p, input logic [3:0] cc);
    logic c, l, f, z, n;
    c = p[0]; l = p[2]; f = p[5]; z = p[6]; n = p[7];
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return l;
      4'd5:  return !l;
      4'd6:  return n;
      4'd7:  return !n;
      4'd8:  return f;
      4'd9:  return !f;
      4'd10: return !l && !z;
      4'd11: return l || z;
      4'd12: return !n && !z;
      4'd13: return n || z;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Model state and compare process, evaluated mid-cycle on the falling edge.
  logic [15:0] m_psr, m_shadow, m_pc, m_psr_next, m_tgt, m_disp_ext;
  logic        m_valid, m_taken, m_ready, m_t;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        m_psr = 16'h0; m_shadow = 16'h0; m_valid = 1'b0; m_taken = 1'b0; m_pc = 16'h0;
      end
      m_ready = !m_valid || rsp_ready;
      check("model psr_out",     psr_out,     m_psr);
      check("model rsp_valid",   rsp_valid,   m_valid);
      check("model req_ready",   req_ready,   m_ready);
      check("model rsp_taken",   rsp_taken,   m_taken);
      check("model rsp_next_pc", rsp_next_pc, m_pc);
      if (reset_n) begin
        m_psr_next = m_psr;
        if (we_cf)  m_psr_next = (m_psr_next & ~16'h0021) | (flags_in & 16'h0021);
        if (we_lnz) m_psr_next = (m_psr_next & ~16'h00C4) | (flags_in & 16'h00C4);
`ifdef PSR_SHADOW_EN
        if (psr_restore) m_psr_next = m_shadow;
        else if (psr_save) m_shadow = m_psr;
`endif
        if (req_valid && m_ready) begin
          m_t        = model_cond(m_psr_next, req_cond);
          m_disp_ext = {{8{req_disp[7]}}, req_disp};
          m_tgt      = req_is_jump ? req_target : req_pc + m_disp_ext;
          m_valid    = 1'b1;
          m_taken    = m_t;
          m_pc       = m_t ? m_tgt : req_pc + 16'd1;
        end else if (m_valid && rsp_ready) begin
          m_valid = 1'b0;
        end
        m_psr = m_psr_next;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "bench did not finish");
  end

  logic [15:0] taken_mask;

  initial begin
    reset_n = 1'b0; flags_in = '0; we_cf = 1'b0; we_lnz = 1'b0;
    req_valid = 1'b0; req_cond = '0; req_is_jump = 1'b0; req_pc = '0;
    req_disp = '0; req_target = '0; rsp_ready = 1'b1;
    psr_save = 1'b0; psr_restore = 1'b0;
    repeat (3) tick();
    check("reset psr_out",     psr_out,     16'h0000);
    check("reset rsp_valid",   rsp_valid,   1'b0);
    check("reset req_ready",   req_ready,   1'b1);
    check("reset rsp_taken",   rsp_taken,   1'b0);
    check("reset rsp_next_pc", rsp_next_pc, 16'h0000);
    reset_n = 1'b1;
    tick();

    // Flag capture: only L, Z, N load.
    flags_in = 16'h00E5; we_lnz = 1'b1;
    tick();
    we_lnz = 1'b0;
    check("capture lnz", psr_out, 16'h00C4);

    // PSR = Z only, then sweep all codes back-to-back.
    flags_in = 16'h0040; we_lnz = 1'b1;
    tick();
    we_lnz = 1'b0;
    check("psr z only", psr_out, 16'h0040);
    taken_mask = 16'h6AA9;
    for (int i = 0; i < 16; i++) begin
      issue(4'(i), i[0], 16'h0100 + 16'(i), 8'hF0, 16'h2000 + 16'(i));
      tick();
      check("sweep rsp_valid", rsp_valid, 1'b1);
      check($sformatf("sweep taken code %0d", i), rsp_taken, taken_mask[i]);
    end
    req_valid = 1'b0;
    tick();

    // Bcond wrap-around.
    issue(4'hE, 1'b0, 16'hFFFE, 8'h03, 16'h0);
    tick();
    check("wrap UC next_pc", rsp_next_pc, 16'h0001);
    issue(4'h1, 1'b0, 16'hFFFE, 8'h03, 16'h0);
    tick();
    check("wrap NE next_pc", rsp_next_pc, 16'hFFFF);
    req_valid = 1'b0;
    tick();

    // Bypass: Z written the same cycle as an EQ request.
    flags_in = 16'h0000; we_lnz = 1'b1;
    tick();
    flags_in = 16'h0040;
    issue(4'h0, 1'b0, 16'h0300, 8'h10, 16'h0);
    tick();
    we_lnz = 1'b0; req_valid = 1'b0;
    check("bypass taken",   rsp_taken,   1'b1);
    check("bypass next_pc", rsp_next_pc, 16'h0310);
    tick();

    // Backpressure while flags change underneath the held response.
    rsp_ready = 1'b0;
    issue(4'h0, 1'b0, 16'h0010, 8'h05, 16'h0);
    tick();
    issue(4'h0, 1'b0, 16'h0020, 8'h05, 16'h0);
    we_lnz = 1'b1;
    for (int k = 0; k < 3; k++) begin
      flags_in = (k == 1) ? 16'h00C4 : 16'h0000;
      tick();
      check("hold rsp_valid", rsp_valid,   1'b1);
      check("hold taken",     rsp_taken,   1'b1);
      check("hold next_pc",   rsp_next_pc, 16'h0015);
      check("hold req_ready", req_ready,   1'b0);
    end
    we_lnz = 1'b0;
    rsp_ready = 1'b1;
    #1;
    check("release req_ready", req_ready, 1'b1);
    tick();
    check("release taken",   rsp_taken,   1'b0);
    check("release next_pc", rsp_next_pc, 16'h0021);
    req_valid = 1'b0;
    tick();

    // Asynchronous reset while a response is held.
    flags_in = 16'h0085; we_cf = 1'b1; we_lnz = 1'b1;
    tick();
    we_cf = 1'b0; we_lnz = 1'b0;
    rsp_ready = 1'b0;
    issue(4'hE, 1'b1, 16'h0040, 8'h00, 16'h4321);
    tick();
    check("pre-reset rsp_valid", rsp_valid, 1'b1);
    #1 reset_n = 1'b0;
    #1;
    check("async reset rsp_valid", rsp_valid, 1'b0);
    check("async reset psr_out",   psr_out,   16'h0000);
    req_valid = 1'b0; rsp_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    tick();

`ifdef PSR_SHADOW_EN
    flags_in = 16'h0085; we_cf = 1'b1; we_lnz = 1'b1;
    tick();
    we_cf = 1'b0; we_lnz = 1'b0; psr_save = 1'b1;
    tick();
    psr_save = 1'b0; flags_in = 16'h0000; we_cf = 1'b1; we_lnz = 1'b1;
    tick();
    we_cf = 1'b0; we_lnz = 1'b0;
    check("shadow cleared psr", psr_out, 16'h0000);
    psr_restore = 1'b1;
    tick();
    check("shadow restore psr", psr_out, 16'h0085);
    flags_in = 16'h0000; we_cf = 1'b1; we_lnz = 1'b1; psr_save = 1'b1;
    issue(4'h6, 1'b1, 16'h0000, 8'h00, 16'hBEEF);
    tick();
    psr_save = 1'b0; psr_restore = 1'b0; we_cf = 1'b0; we_lnz = 1'b0; req_valid = 1'b0;
    check("restore+save psr",   psr_out,     16'h0085);
    check("restore bypass pc",  rsp_next_pc, 16'hBEEF);
    tick();
`endif

    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
